pkt_prior_sched: RTL and testbench
==================================

PKT_PRIOR_SCHED -- requirements
Module: pkt_prior_sched

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32: packet data width.
REQ-002 The block SHALL have parameter PRIOR_WIDTH, default 6: priority tag width; the value 0 means "unassigned".
REQ-003 The block SHALL have parameter DEPTH, default 8, a power of 2: entries per class FIFO.
REQ-004 The block SHALL have parameter STARVE_LIM, default 15, range 1..15: the anti-starvation threshold.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low (0 = reset).
REQ-007 The block SHALL have port in_valid, input, 1 bit: the upstream priority-tagged packet is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept the presented packet.
REQ-009 The block SHALL have port in_data, input, DWIDTH bits: packet data.
REQ-010 The block SHALL have port in_prior, input, PRIOR_WIDTH bits: the priority tag; a smaller nonzero value is more urgent.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the output register holds a packet.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts the packet.
REQ-013 The block SHALL have port out_data, output, DWIDTH bits: the scheduled packet data.
REQ-014 The block SHALL have port out_prior, output, PRIOR_WIDTH bits: the scheduled packet's priority tag.
REQ-015 The block SHALL have port out_class, output, 2 bits: the class the packet was served from.
REQ-016 The block SHALL have port class_empty, output, 4 bits: bit k is 1 when class FIFO k is empty.
REQ-017 The block SHALL have port drop_cnt, output, 16 bits: a saturating count of dropped unassigned packets.

Function
REQ-018 Class mapping SHALL be class = (in_prior-1) >> (PRIOR_WIDTH-2), giving 4 classes; class 0 is the most urgent.
REQ-019 There SHALL be 4 independent class FIFOs, each of depth DEPTH and holding {data, prior}, with pointers that wrap modulo DEPTH and a separate occupancy count from 0 to DEPTH.
REQ-020 in_ready SHALL be combinational: 1 if in_prior==0, otherwise 1 when the target class FIFO is not full; it SHALL NOT depend on a same-cycle pop.
REQ-021 An accept SHALL occur when in_valid && in_ready; on an accept with prior!=0, the packet SHALL be written to its class FIFO at that edge.
REQ-022 An accept with prior==0 SHALL discard the packet and increment drop_cnt, saturating at 16'hFFFF.
REQ-023 The output register SHALL load at an edge when (!out_valid || out_ready) and at least one FIFO is nonempty; the granted FIFO SHALL pop at the same edge.
REQ-024 When (!out_valid || out_ready) holds and all FIFOs are empty, out_valid SHALL clear at that edge.
REQ-025 out_data, out_prior and out_class SHALL hold stable while out_valid && !out_ready.
REQ-026 Grant: if any class k has wait_cnt[k]==STARVE_LIM, the grant SHALL go to the lowest such k; otherwise it SHALL go to the lowest-index nonempty class.
REQ-027 wait_cnt[k] (4-bit) SHALL be cleared when class k is granted or is empty, SHALL be incremented (saturating at STARVE_LIM) on each load granting another class while class k is nonempty, and SHALL otherwise hold.
REQ-028 Latency: a packet accepted in cycle c into an idle block SHALL be presented with out_valid=1 in cycle c+2.
REQ-029 A push and a pop on the same class at the same edge SHALL leave the occupancy unchanged and keep the data correct, including at occupancy 1.
REQ-030 Packet order within a class SHALL be FIFO; across classes, only the grant rule SHALL order packets.
REQ-031 class_empty SHALL reflect the registered occupancy (count==0).

Reset
REQ-032 While rst==0, all FIFO pointers and counts, all wait_cnt and drop_cnt SHALL be 0; out_valid SHALL be 0; out_data, out_prior and out_class SHALL be 0; class_empty SHALL be 4'b1111.
REQ-033 Reset asserted mid-operation SHALL discard all queued and held packets immediately, without waiting for a clock edge.
REQ-034 After rst deasserts, the first accept SHALL be possible in the first cycle.

Verification
REQ-035 Push prior=5, data=0xA5 into an idle block, out_ready=1 -> out_valid=1 two cycles later with out_data=0xA5, out_prior=5, out_class=0, then out_valid=0.
REQ-036 With out_ready=0, push prior 40, 3, 63, 20 -> serve order after out_ready=1 is prior 3 (class 0), 20 (class 1), 40 (class 2), 63 (class 3).
REQ-037 Fill class 1 with 8 packets while out_ready=0 -> in_ready=0 for prior 17..32 and in_ready=1 for prior 5; a 9th push is not accepted; contents drain intact and in order.
REQ-038 Keep class 0 continuously fed, one class-3 packet queued, out_ready=1 -> the class-3 packet is granted on the 16th load, wait_cnt[3] then clears, and class 0 resumes.
REQ-039 Push 3 packets with prior=0 -> drop_cnt=3, no out_valid; with drop_cnt preloaded to 0xFFFE, 3 more drops -> drop_cnt=0xFFFF.
REQ-040 Drive rst=0 asynchronously while out_valid=1 and FIFOs are nonempty -> out_valid=0 and class_empty=4'b1111 without waiting for a clk edge, and no stale packet appears after release.

Source files
------------

// File: rtl/pkt_prior_sched_if.sv
// Handshake bundle for pkt_prior_sched: priority-tagged input stream,
// scheduled output stream and status outputs.
interface pkt_prior_sched_if #(
  parameter int DWIDTH      = 32,
  parameter int PRIOR_WIDTH = 6
);
  logic                   in_valid;
  logic                   in_ready;
  logic [DWIDTH-1:0]      in_data;
  logic [PRIOR_WIDTH-1:0] in_prior;
  logic                   out_valid;
  logic                   out_ready;
  logic [DWIDTH-1:0]      out_data;
  logic [PRIOR_WIDTH-1:0] out_prior;
  logic [1:0]             out_class;
  logic [3:0]             class_empty;
  logic [15:0]            drop_cnt;

  modport master (
    output in_valid, in_data, in_prior, out_ready,
    input  in_ready, out_valid, out_data, out_prior, out_class, class_empty, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, in_prior, out_ready,
    output in_ready, out_valid, out_data, out_prior, out_class, class_empty, drop_cnt
  );
endinterface

// File: rtl/pkt_prior_sched.sv
// Four-class strict-priority packet scheduler with per-class FIFOs,
// anti-starvation promotion and a registered output stage.
module pkt_prior_sched #(
  parameter int DWIDTH      = 32,
  parameter int PRIOR_WIDTH = 6,
  parameter int DEPTH       = 8,
  parameter int STARVE_LIM  = 15
) (
  input logic              clk,
  input logic              rst,
  pkt_prior_sched_if.slave bus
);
  localparam int              AW   = $clog2(DEPTH);
  localparam int              EW   = DWIDTH + PRIOR_WIDTH;
  localparam logic [3:0]      LIM  = 4'(STARVE_LIM);
  localparam logic [AW:0]     FULL = (AW+1)'(DEPTH);

  logic [EW-1:0]          r_mem [4][DEPTH];
  logic [AW-1:0]          r_wptr [4];
  logic [AW-1:0]          r_rptr [4];
  logic [AW:0]            r_cnt [4];
  logic [3:0]             r_wait [4];
  logic                   r_out_valid;
  logic [DWIDTH-1:0]      r_out_data;
  logic [PRIOR_WIDTH-1:0] r_out_prior;
  logic [1:0]             r_out_class;
  logic [15:0]            r_drop_cnt;

  logic                   w_prior_zero;
  logic [1:0]             w_in_class;
  logic                   w_in_ready;
  logic                   w_push;
  logic                   w_drop;
  logic [3:0]             w_nonempty;
  logic [3:0]             w_full;
  logic [3:0]             w_starved;
  logic                   w_load;
  logic [1:0]             w_grant;
  logic [3:0]             w_push_v;
  logic [3:0]             w_pop_v;
  logic [EW-1:0]          w_head;

  always_comb begin
    w_prior_zero = (bus.in_prior == '0);
    w_in_class   = 2'((bus.in_prior - PRIOR_WIDTH'(1)) >> (PRIOR_WIDTH - 2));
    for (int unsigned k = 0; k < 4; k++) begin
      w_nonempty[k] = (r_cnt[k] != '0);
      w_full[k]     = (r_cnt[k] == FULL);
      w_starved[k]  = w_nonempty[k] && (r_wait[k] == LIM);
    end
    // Ready looks only at registered occupancy so it never waits on a same-edge pop.
    w_in_ready = w_prior_zero || !w_full[w_in_class];
    w_push     = bus.in_valid && w_in_ready && !w_prior_zero;
    w_drop     = bus.in_valid && w_prior_zero;
    w_load     = (!r_out_valid || bus.out_ready) && (|w_nonempty);

    w_grant = '0;
    for (int unsigned i = 0; i < 4; i++)
      if (w_nonempty[3-i]) w_grant = 2'(3 - i);
    if (|w_starved)
      for (int unsigned i = 0; i < 4; i++)
        if (w_starved[3-i]) w_grant = 2'(3 - i);

    for (int unsigned k = 0; k < 4; k++) begin
      w_push_v[k] = w_push && (w_in_class == 2'(k));
      w_pop_v[k]  = w_load && (w_grant == 2'(k));
    end
    w_head = r_mem[w_grant][r_rptr[w_grant]];
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_in_class][r_wptr[w_in_class]] <= {bus.in_data, bus.in_prior};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < 4; k++) begin
        r_wptr[k] <= '0;
        r_rptr[k] <= '0;
        r_cnt[k]  <= '0;
        r_wait[k] <= '0;
      end
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_prior <= '0;
      r_out_class <= '0;
      r_drop_cnt  <= '0;
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (w_push_v[k]) r_wptr[k] <= r_wptr[k] + AW'(1);
        if (w_pop_v[k])  r_rptr[k] <= r_rptr[k] + AW'(1);
        case ({w_push_v[k], w_pop_v[k]})
          2'b10:   r_cnt[k] <= r_cnt[k] + (AW+1)'(1);
          2'b01:   r_cnt[k] <= r_cnt[k] - (AW+1)'(1);
          default: r_cnt[k] <= r_cnt[k];
        endcase
        if (!w_nonempty[k] || w_pop_v[k])
          r_wait[k] <= '0;
        else if (w_load && (r_wait[k] != LIM))
          r_wait[k] <= r_wait[k] + 4'd1;
      end

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_head[EW-1 -: DWIDTH];
        r_out_prior <= w_head[PRIOR_WIDTH-1:0];
        r_out_class <= w_grant;
      end else if (!r_out_valid || bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.out_prior   = r_out_prior;
  assign bus.out_class   = r_out_class;
  assign bus.class_empty = ~w_nonempty;
  assign bus.drop_cnt    = r_drop_cnt;
endmodule

// File: tb/tb_pkt_prior_sched.sv
// Directed self-checking bench for pkt_prior_sched.
module tb_pkt_prior_sched;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [31:0] q_data [$];
  logic [5:0]  q_prior [$];
  logic [1:0]  q_class [$];

  pkt_prior_sched_if #(.DWIDTH(32), .PRIOR_WIDTH(6)) bus ();

  pkt_prior_sched #(
    .DWIDTH(32),
    .PRIOR_WIDTH(6),
    .DEPTH(8),
    .STARVE_LIM(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic push(input logic [5:0] p, input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_prior = p;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Gathers up to n output transfers within a cycle budget.
  task automatic collect(input int n, input int budget);
    q_data.delete();
    q_prior.delete();
    q_class.delete();
    bus.out_ready = 1'b1;
    for (int c = 0; c < budget && q_data.size() < n; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        q_data.push_back(bus.out_data);
        q_prior.push_back(bus.out_prior);
        q_class.push_back(bus.out_class);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    n_vec++; if (bus.out_data !== 32'h0) begin n_err++; $display("FAIL rst_out_data: got %h expected 0", bus.out_data); end
    n_vec++; if (bus.out_prior !== 6'd0 || bus.out_class !== 2'd0) begin n_err++; $display("FAIL rst_out_tag: got prior %0d class %0d expected 0 0", bus.out_prior, bus.out_class); end
    n_vec++; if (bus.class_empty !== 4'b1111) begin n_err++; $display("FAIL rst_class_empty: got %b expected 1111", bus.class_empty); end
    n_vec++; if (bus.drop_cnt !== 16'h0) begin n_err++; $display("FAIL rst_drop_cnt: got %h expected 0", bus.drop_cnt); end
    @(negedge clk);
    rst = 1'b1;
    bus.in_prior = 6'd5;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_latency();
    do_reset();
    bus.out_ready = 1'b1;
    push(6'd5, 32'hA5);
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL lat_c1_valid: got %b expected 0", bus.out_valid); end
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL lat_c2_valid: got %b expected 1", bus.out_valid); end
    n_vec++; if (bus.out_data !== 32'hA5 || bus.out_prior !== 6'd5 || bus.out_class !== 2'd0) begin
      n_err++; $display("FAIL lat_c2_pkt: got data %h prior %0d class %0d expected a5 5 0", bus.out_data, bus.out_prior, bus.out_class);
    end
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL lat_c3_valid: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_class_order();
    logic [5:0]  exp_p [5];
    logic [1:0]  exp_c [5];
    logic [31:0] exp_d [5];
    exp_p = '{6'd1, 6'd3, 6'd20, 6'd40, 6'd63};
    exp_c = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    exp_d = '{32'h11, 32'h03, 32'h20, 32'h40, 32'h63};
    do_reset();
    bus.out_ready = 1'b0;
    push(6'd1, 32'h11);
    push(6'd40, 32'h40);
    push(6'd3, 32'h03);
    push(6'd63, 32'h63);
    push(6'd20, 32'h20);
    collect(5, 30);
    n_vec++; if (q_data.size() != 5) begin n_err++; $display("FAIL order_count: got %0d expected 5", q_data.size()); end
    for (int i = 0; i < q_data.size() && i < 5; i++) begin
      n_vec++;
      if (q_prior[i] !== exp_p[i] || q_class[i] !== exp_c[i] || q_data[i] !== exp_d[i]) begin
        n_err++;
        $display("FAIL order_%0d: got prior %0d class %0d data %h expected %0d %0d %h",
                 i, q_prior[i], q_class[i], q_data[i], exp_p[i], exp_c[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) push(6'(17 + i), 32'h100 + 32'(i));
    bus.in_prior = 6'd17;
    #1;
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL full_rdy17: got %b expected 0", bus.in_ready); end
    bus.in_prior = 6'd32;
    #1;
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL full_rdy32: got %b expected 0", bus.in_ready); end
    bus.in_prior = 6'd5;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL full_rdy5: got %b expected 1", bus.in_ready); end
    n_vec++; if (bus.class_empty !== 4'b1101) begin n_err++; $display("FAIL full_empty: got %b expected 1101", bus.class_empty); end
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h100) begin
      n_err++; $display("FAIL full_hold: got valid %b data %h expected 1 100", bus.out_valid, bus.out_data);
    end
    push(6'd20, 32'h1FF);
    collect(10, 40);
    n_vec++; if (q_data.size() != 9) begin n_err++; $display("FAIL full_drain_count: got %0d expected 9", q_data.size()); end
    for (int i = 0; i < q_data.size() && i < 9; i++) begin
      n_vec++;
      if (q_data[i] !== 32'h100 + 32'(i) || q_prior[i] !== 6'(17 + i) || q_class[i] !== 2'd1) begin
        n_err++;
        $display("FAIL full_drain_%0d: got data %h prior %0d class %0d expected %h %0d 1",
                 i, q_data[i], q_prior[i], q_class[i], 32'h100 + 32'(i), 17 + i);
      end
    end
    n_vec++; if (bus.out_valid !== 1'b0 || bus.class_empty !== 4'b1111) begin
      n_err++; $display("FAIL full_idle: got valid %b empty %b expected 0 1111", bus.out_valid, bus.class_empty);
    end
  endtask

  task automatic test_starve();
    do_reset();
    bus.out_ready = 1'b0;
    push(6'd1, 32'h200);
    push(6'd63, 32'h3EE);
    for (int i = 1; i <= 4; i++) push(6'd1, 32'h200 + 32'(i));
    q_data.delete();
    q_class.delete();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_prior  = 6'd1;
    bus.in_data   = 32'h205;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        q_data.push_back(bus.out_data);
        q_class.push_back(bus.out_class);
      end
      step();
      bus.in_data = bus.in_data + 32'd1;
    end
    bus.in_valid = 1'b0;
    n_vec++; if (q_data.size() != 18) begin n_err++; $display("FAIL starve_count: got %0d expected 18", q_data.size()); end
    for (int i = 0; i < q_data.size() && i < 16; i++) begin
      n_vec++;
      if (q_class[i] !== 2'd0 || q_data[i] !== 32'h200 + 32'(i)) begin
        n_err++; $display("FAIL starve_c0_%0d: got class %0d data %h expected 0 %h", i, q_class[i], q_data[i], 32'h200 + 32'(i));
      end
    end
    if (q_data.size() == 18) begin
      n_vec++; if (q_class[16] !== 2'd3 || q_data[16] !== 32'h3EE) begin
        n_err++; $display("FAIL starve_grant16: got class %0d data %h expected 3 3ee", q_class[16], q_data[16]);
      end
      n_vec++; if (q_class[17] !== 2'd0 || q_data[17] !== 32'h210) begin
        n_err++; $display("FAIL starve_resume: got class %0d data %h expected 0 210", q_class[17], q_data[17]);
      end
    end
    @(negedge clk);
    n_vec++; if (bus.class_empty[3] !== 1'b1) begin n_err++; $display("FAIL starve_c3_empty: got %b expected 1", bus.class_empty[3]); end
  endtask

  task automatic test_drop();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(6'd0, 32'hD0 + 32'(i));
    @(negedge clk);
    n_vec++; if (bus.drop_cnt !== 16'd3) begin n_err++; $display("FAIL drop_3: got %h expected 0003", bus.drop_cnt); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL drop_no_out_a: got %b expected 0", bus.out_valid); end
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b0 || bus.class_empty !== 4'b1111) begin
      n_err++; $display("FAIL drop_no_out_b: got valid %b empty %b expected 0 1111", bus.out_valid, bus.class_empty);
    end
    bus.in_valid = 1'b1;
    bus.in_prior = 6'd0;
    repeat (65531) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n_vec++; if (bus.drop_cnt !== 16'hFFFE) begin n_err++; $display("FAIL drop_fffe: got %h expected fffe", bus.drop_cnt); end
    for (int i = 0; i < 3; i++) push(6'd0, 32'hE0);
    n_vec++; if (bus.drop_cnt !== 16'hFFFF) begin n_err++; $display("FAIL drop_sat: got %h expected ffff", bus.drop_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.out_ready = 1'b0;
    push(6'd1, 32'h31);
    push(6'd20, 32'h32);
    push(6'd40, 32'h33);
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b1 || bus.class_empty !== 4'b1001) begin
      n_err++; $display("FAIL arst_pre: got valid %b empty %b expected 1 1001", bus.out_valid, bus.class_empty);
    end
    #2;
    rst = 1'b0;
    #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b expected 0", bus.out_valid); end
    n_vec++; if (bus.class_empty !== 4'b1111 || bus.out_data !== 32'h0) begin
      n_err++; $display("FAIL arst_state: got empty %b data %h expected 1111 0", bus.class_empty, bus.out_data);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_prior  = 6'd5;
    bus.in_data   = 32'h77;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL arst_first_rdy: got %b expected 1", bus.in_ready); end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL arst_c1: got %b expected 0", bus.out_valid); end
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h77) begin
      n_err++; $display("FAIL arst_c2: got valid %b data %h expected 1 77", bus.out_valid, bus.out_data);
    end
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b0 || bus.class_empty !== 4'b1111) begin
      n_err++; $display("FAIL arst_no_stale: got valid %b empty %b expected 0 1111", bus.out_valid, bus.class_empty);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_prior  = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_latency();
    test_class_order();
    test_full();
    test_starve();
    test_drop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
